// File: rtl/int_divider_pkg.sv
// int_divider_pkg
// Purpose: shared definitions for the iterative integer divider. The op
//   encoding matches the CPU decoder (bit 0 = unsigned, bit 1 = remainder)
//   so issue logic can pass its decoded field straight through.
// Contents: op constants, FSM state type, op classification helpers.
package int_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } div_state_t;

  function automatic logic op_is_unsigned(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/int_divider_step.sv
// int_divider_step
// Purpose: one combinational restoring-division step. Shifts {rem, quo}
//   left by one, trial-subtracts the divisor from the widened remainder and
//   keeps the difference only when it does not go negative.
// Ports:
//   rem, quo    partial remainder and dividend/quotient before the step
//   divisor     magnitude of the divisor
//   rem_next    partial remainder after the step
//   quo_next    dividend/quotient after the step, new quotient bit in LSB
module int_divider_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    shifted = {rem, quo[N-1]};
    diff    = shifted - {1'b0, divisor};
    // diff[N] is the borrow: set means the trial subtraction went negative
    rem_next = diff[N] ? shifted[N-1:0] : diff[N-1:0];
    quo_next = {quo[N-2:0], ~diff[N]};
  end

endmodule

// File: rtl/int_divider.sv
// int_divider
// Purpose: iterative signed/unsigned integer divider for the execute stage.
//   Resolves M quotient bits per cycle via a chain of restoring steps, so a
//   full N-bit result takes N/M CALC cycles. Shares the valid/ready handshake
//   of the integer multiplier.
// Build option: define INT_DIV_FUSE_EN to answer a DIV/REM (or DIVU/REMU)
//   pair on identical operands from the previous result without recomputing.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   valid_in     upstream presents op/a/b
//   ready_out    unit can accept (ready_in && idle)
//   op, a, b     operation, dividend, divisor
//   valid_out    y holds a valid result
//   ready_in     downstream accepts y
//   y            quotient or remainder, sign-corrected
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an accept; holds last result while valid_out set
// ST_CALC | running N/M cycles of M restoring steps each
module int_divider
  import int_divider_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  output logic         ready_out,
  output logic         valid_out,
  input  logic         ready_in,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  localparam int STEPS = N / M;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  div_state_t     state;
  logic [CNT_W-1:0] counter;
  logic [2*N-1:0] reg_res;
  logic [N-1:0]   reg_div;
  logic [1:0]     reg_op;
  logic           qsgn;
  logic           rsgn;

  logic           accept;
  logic           fuse_hit;
  logic           signed_op;
  logic [N-1:0]   a_abs;
  logic [N-1:0]   b_abs;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;

  logic [M:0][N-1:0] rem_chain;
  logic [M:0][N-1:0] quo_chain;

`ifdef INT_DIV_FUSE_EN
  logic           done;
  logic [N-1:0]   prev_a;
  logic [N-1:0]   prev_b;

  // Same signedness, opposite kind: the other half of the last result.
  assign fuse_hit = done && (prev_a == a) && (prev_b == b) &&
                    (op_is_unsigned(op) == op_is_unsigned(reg_op)) &&
                    (op_is_rem(op) != op_is_rem(reg_op));
`else
  assign fuse_hit = 1'b0;
`endif

  assign ready_out = ready_in && (state == ST_IDLE);
  assign accept    = valid_in && ready_out;

  always_comb begin
    signed_op = !op_is_unsigned(op);
    a_abs     = (signed_op && a[N-1]) ? -a : a;
    b_abs     = (signed_op && b[N-1]) ? -b : b;
  end

  assign rem_chain[0] = reg_res[2*N-1:N];
  assign quo_chain[0] = reg_res[N-1:0];

  for (genvar i = 0; i < M; i++) begin : g_step
    int_divider_step #(.N(N)) u_step (
      .rem      (rem_chain[i]),
      .quo      (quo_chain[i]),
      .divisor  (reg_div),
      .rem_next (rem_chain[i+1]),
      .quo_next (quo_chain[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      valid_out <= 1'b0;
      counter   <= '0;
      reg_res   <= '0;
      reg_div   <= '0;
      reg_op    <= OP_DIV;
      qsgn      <= 1'b0;
      rsgn      <= 1'b0;
`ifdef INT_DIV_FUSE_EN
      done      <= 1'b0;
      prev_a    <= '0;
      prev_b    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            reg_op <= op;
            if (fuse_hit) begin
              valid_out <= 1'b1;
            end else begin
              state     <= ST_CALC;
              valid_out <= 1'b0;
              counter   <= '0;
              reg_res   <= {{N{1'b0}}, a_abs};
              reg_div   <= b_abs;
              // Quotient sign forced positive on divide-by-zero so the
              // natural all-ones quotient is returned unchanged.
              qsgn      <= signed_op && (a[N-1] ^ b[N-1]) && (b != '0);
              rsgn      <= signed_op && a[N-1];
`ifdef INT_DIV_FUSE_EN
              done      <= 1'b0;
              prev_a    <= a;
              prev_b    <= b;
`endif
            end
          end else if (ready_in) begin
            valid_out <= 1'b0;
          end
        end
        ST_CALC: begin
          reg_res <= {rem_chain[M], quo_chain[M]};
          counter <= counter + 1'b1;
          if (counter == CNT_LAST) begin
            state     <= ST_IDLE;
            valid_out <= 1'b1;
`ifdef INT_DIV_FUSE_EN
            done      <= 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign quo = reg_res[N-1:0];
  assign rem = reg_res[2*N-1:N];

  always_comb begin
    if (op_is_rem(reg_op)) y = rsgn ? -rem : rem;
    else                   y = qsgn ? -quo : quo;
  end

endmodule

// File: tb/tb_int_divider.sv
module tb_int_divider;
  import int_divider_pkg::*;

  localparam int N = 32;
  localparam int M = 4;
  localparam int LAT = N / M;
`ifdef INT_DIV_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif
  localparam int FLAT = FUSE ? 0 : LAT;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic         valid_out;
  logic         ready_in = 1'b1;
  logic [1:0]   op = OP_DIV;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] y;

  int checks = 0;
  int failures = 0;

  int_divider #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .op        (op),
    .a         (a),
    .b         (b),
    .y         (y)
  );

  always #5 clk = ~clk;

  // Reference result from plain arithmetic.
  function automatic logic [N-1:0] ref_result(input logic [1:0] o,
                                              input logic [N-1:0] x,
                                              input logic [N-1:0] d);
    logic [N-1:0] q, r;
    if (d == '0) begin
      q = '1;
      r = x;
    end else if (o == OP_DIVU || o == OP_REMU) begin
      q = x / d;
      r = x % d;
    end else if (x == {1'b1, {(N-1){1'b0}}} && d == '1) begin
      q = x;
      r = '0;
    end else begin
      q = $signed(x) / $signed(d);
      r = $signed(x) % $signed(d);
    end
    return (o == OP_REM || o == OP_REMU) ? r : q;
  endfunction

  function automatic bit is_pair(input logic [1:0] x, input logic [1:0] p);
    bit xu, pu, xr, pr;
    xu = (x == OP_DIVU || x == OP_REMU);
    pu = (p == OP_DIVU || p == OP_REMU);
    xr = (x == OP_REM || x == OP_REMU);
    pr = (p == OP_REM || p == OP_REMU);
    return (xu == pu) && (xr != pr);
  endfunction

  // Transaction-level model of the handshake and result.
  bit           m_live = 0;
  bit           m_busy = 0;
  bit           m_vo = 0;
  bit           m_done = 0;
  int           m_cnt = 0;
  logic [1:0]   m_op = OP_DIV;
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_b = '0;
  logic [N-1:0] m_y = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1;
      m_busy = 0;
      m_vo = 0;
      m_done = 0;
      m_cnt = 0;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 0;
        m_vo = 1;
        m_done = 1;
        m_y = ref_result(m_op, m_a, m_b);
      end
    end else if (valid_in && ready_in) begin
      if (FUSE && m_done && a == m_a && b == m_b && is_pair(op, m_op)) begin
        m_op = op;
        m_vo = 1;
        m_y = ref_result(op, a, b);
      end else begin
        m_busy = 1;
        m_cnt = LAT;
        m_vo = 0;
        m_done = 0;
        m_op = op;
        m_a = a;
        m_b = b;
      end
    end else if (ready_in) begin
      m_vo = 0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live && !reset) begin
      checks++;
      if (valid_out !== m_vo) begin
        failures++;
        $display("FAIL model_valid_out t=%0t: got %b expected %b", $time, valid_out, m_vo);
      end
      checks++;
      if (ready_out !== (ready_in && !m_busy)) begin
        failures++;
        $display("FAIL model_ready_out t=%0t: got %b expected %b", $time, ready_out, ready_in && !m_busy);
      end
      if (m_vo) begin
        checks++;
        if (y !== m_y) begin
          failures++;
          $display("FAIL model_y t=%0t: got 0x%08h expected 0x%08h", $time, y, m_y);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at posedge+1 with the unit idle; returns at posedge+1 with valid_out seen.
  task automatic run(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                     input logic [N-1:0] lit, input int lat, input logic rdy_after,
                     input string nm);
    int t;
    ready_in = 1'b1;
    valid_in = 1'b1;
    op = o;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    ready_in = rdy_after;
    t = 0;
    while (!valid_out && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no valid_out within %0d cycles", nm, t);
    end else begin
      check({nm, "_latency"}, N'(t), N'(lat));
      check({nm, "_y"}, y, lit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_valid_out", N'(valid_out), N'(0));
    check("reset_ready_out_hi", N'(ready_out), N'(1));
    ready_in = 1'b0;
    #1;
    check("reset_ready_out_lo", N'(ready_out), N'(0));
    @(posedge clk);
    #1;

    run(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT, 1'b1, "divu_100_7");
    run(OP_REMU, 32'd100, 32'd7, 32'd2, FLAT, 1'b1, "remu_100_7");
    run(OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, LAT, 1'b1, "div_m7_2");
    run(OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, FLAT, 1'b1, "rem_m7_2");
    run(OP_REM, 32'd7, -32'sd2, 32'd1, LAT, 1'b1, "rem_7_m2");
    run(OP_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF, LAT, 1'b1, "div_m5_0");
    run(OP_REM, -32'sd5, 32'd0, 32'hFFFF_FFFB, FLAT, 1'b1, "rem_m5_0");
    run(OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, LAT, 1'b1, "divu_9_0");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT, 1'b1, "div_ovf");
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FLAT, 1'b1, "rem_ovf");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FLAT, 1'b1, "div_ovf_again");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT, 1'b1, "div_ovf_same_kind");

    // Back-pressure: result held while downstream stalls.
    run(OP_DIVU, 32'd1000, 32'd10, 32'd100, LAT, 1'b0, "bp_divu");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", N'(valid_out), N'(1));
      check("bp_hold_y", y, 32'd100);
      check("bp_hold_ready_out", N'(ready_out), N'(0));
    end
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", N'(valid_out), N'(0));
    check("bp_release_ready_out", N'(ready_out), N'(1));

    // Reset in the third CALC cycle discards the computation.
    valid_in = 1'b1;
    op = OP_DIVU;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("calc_ready_out", N'(ready_out), N'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_valid_out", N'(valid_out), N'(0));
    check("abort_ready_out", N'(ready_out), N'(1));
    run(OP_REMU, 32'd100, 32'd7, 32'd2, LAT, 1'b1, "remu_after_abort");

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_divider.md
# int_divider

Iterative integer divider for the CPU execute stage. It computes the signed and unsigned quotient and remainder of two n-bit operands, resolving m quotient bits per cycle by restoring division. It sits beside the integer multiplier and uses the same valid/ready handshake, so the issue logic can drive both units identically. Quotient and remainder come from one computation, so a DIV/REM pair on identical operands is answered without recomputing.

## Interface
- n, 32, operand and result width.
- m, 4, quotient bits resolved per cycle. Must divide n.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream presents op/a/b.
- ready_out  out  1  equals ready_in && state==IDLE.
- valid_out  out  1  y holds a valid result.
- ready_in  in  1  downstream accepts y.
- op  in  2  DIV, DIVU, REM or REMU (CPU_pkg encoding).
- a  in  n  dividend.
- b  in  n  divisor.
- y  out  n  result; combinational from the registered op, quotient, remainder and sign flags.

## Operation
- **Accept:** an operation is accepted on an edge where valid_in && ready_out.
  - The unit registers op, a and b (the latter two as prev_a/prev_b).
  - It clears counter, enters CALC and drops valid_out.
- **Signed ops (DIV, REM):**
  - Operands are made absolute.
  - qsgn = a[n-1]^b[n-1], forced to 0 when b==0.
  - rsgn = a[n-1].
- **Unsigned ops (DIVU, REMU):** qsgn = rsgn = 0.
- **Working register:** reg_res is 2n bits, {remainder, dividend/quotient}.
- **CALC step, repeated m times per cycle:**
  - Shift reg_res left by 1.
  - Trial-subtract |b| from the upper n+1 bits.
  - If the result is non-negative, keep it and set the new LSB to 1; otherwise set the LSB to 0.
- **CALC exit:** after n/m cycles (counter==n/m-1), set valid_out and enter IDLE.
- **Output y:**
  - DIV/DIVU: quotient (lower half), negated if qsgn.
  - REM/REMU: remainder (upper half), negated if rsgn.
- **Divide by zero:** no special path; the natural result is quotient all-ones and remainder = a.
- **Signed overflow:** -2^(n-1) / -1 gives quotient 0x80000000 and remainder 0 naturally.
- **IDLE with valid_out high:**
  - ready_in high and no new accept: valid_out clears on that edge.
  - A new accept on the same edge takes precedence.
- **States:**
  - IDLE -> CALC on a non-fused accept.
  - CALC -> IDLE on the last step.
  - IDLE -> IDLE on a fused accept (see Configuration).
- **Reset values:** valid_out=0, state=IDLE, counter=0, reg_res=0, reg_op=DIV, prev_a=prev_b=0, qsgn=rsgn=0, done=0.
  - ready_out therefore equals ready_in from the first cycle after reset.
- **Reset mid-CALC:** aborts the computation and discards its result; done=0.

## Timing
- **Non-fused latency:** valid_out rises on the n/m-th edge after the accepting edge (8 edges at the defaults).
- **Fused latency:** valid_out rises on the accepting edge itself.
- **Back-pressure:** ready_out is low throughout CALC.
  - valid_in held during CALC is ignored, not queued.
- **Output stability:** y and valid_out are stable while valid_out && !ready_in.
- **Throughput:** one accept per n/m+1 cycles at best, one per cycle for back-to-back fused pairs.

## Configuration
- **INT_DIV_FUSE_EN defined:** an accept skips CALC when all of the following hold:
  - done==1;
  - prev_a==a and prev_b==b;
  - the new op has the same signedness as reg_op but the opposite kind (DIV<->REM, DIVU<->REMU).
- **On a fused accept:** only reg_op updates and valid_out is set on that edge. done is set on every CALC completion.
- **Undefined:** every accept runs the full CALC sequence, and the done/prev_a/prev_b registers are removed.

## Structure
- **CPU_pkg** holds the op encoding: DIV, DIVU, REM, REMU as 2-bit constants shared with the decoder.
- **int_div_step** is the one natural sub-module.
  - It is a combinational single-bit restoring step: input {rem, quo, divisor}, output the next {rem, quo}.
  - It is instantiated m times in a generate chain.
- **Top level** holds the FSM, counter, sign handling and output mux.

## Test plan
- **DIVU:** a=100, b=7 -> y=14 after 8 cycles. Then REMU on the same operands -> y=2 on the accept edge (fused), or after 8 cycles without the macro.
- **Signed:** DIV a=-7, b=2 -> y=-3 (0xFFFFFFFD). REM with the same operands -> y=-1. REM a=7, b=-2 -> y=1.
- **Divide by zero:** DIV a=-5, b=0 -> 0xFFFFFFFF. REM a=-5, b=0 -> 0xFFFFFFFB. DIVU a=9, b=0 -> 0xFFFFFFFF.
- **Overflow:** DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- **Back-pressure:** hold ready_in=0 while done -> valid_out and y are held and ready_out=0. Raise ready_in for one cycle -> valid_out clears.
- **Reset in CALC:** assert reset on CALC cycle 3 -> next cycle valid_out=0, state=IDLE. A following REMU on the same operands recomputes and is not fused.
